// File: rtl/pic_irq_sequencer.sv
// Clocked 8259-style interrupt sequencer: ICW/OCW decode, fixed-priority resolution,
// two-pulse INTA acknowledge with ISR/IMR bookkeeping and optional auto-EOI.
//
// state  | meaning
// UNINIT | no ICW1 seen since reset
// W_ICW2 | ICW1 taken, waiting for the vector base word
// W_ICW3 | cascade word expected (SNGL=0)
// W_ICW4 | mode word expected (IC4=1)
// READY  | initialised; OCWs and requests are honoured
// A_IDLE | no acknowledge in progress
// A_ACK1 | first INTA pulse seen, winner latched and marked in service
// A_ACK2 | second INTA pulse, vector on the bus until INTA rises
module pic_irq_sequencer #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr,
    input  logic               A0,
    input  logic [7:0]         dataBus,
    input  logic               INTA,
    input  logic [NUM_IRQ-1:0] irr,
    output logic               INT,
    output logic [7:0]         vector_address,
    output logic               Direction,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] imr,
    output logic               init_done
);
    localparam int IDX_W = $clog2(NUM_IRQ);

    typedef enum logic [2:0] {
        UNINIT = 3'd0,
        W_ICW2 = 3'd1,
        W_ICW3 = 3'd2,
        W_ICW4 = 3'd3,
        READY  = 3'd4
    } init_state_t;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_ACK1 = 2'd1,
        A_ACK2 = 2'd2
    } ack_state_t;

    init_state_t        init_q;
    ack_state_t         ack_q;
    logic [7:0]         icw1_q;
    logic [7:0]         icw2_q;
    logic [7:0]         icw3_q;
    logic [7:0]         icw4_q;
    logic [NUM_IRQ-1:0] imr_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic [NUM_IRQ-1:0] isr_d;
    logic [IDX_W-1:0]   idx_q;
    logic               spur_q;
    logic               int_q;
    logic [7:0]         vec_q;
    logic               dir_q;
    logic               inta_q;

    logic               inta_fall;
    logic               inta_rise;
    logic               icw1_wr;
    logic               ocw2_eoi;
    logic [NUM_IRQ-1:0] eligible;
    logic               any_elig;
    logic [IDX_W-1:0]   win_idx;
    logic               blocked;
    logic               found;

    assign inta_fall = inta_q & ~INTA;
    assign inta_rise = ~inta_q & INTA;
    assign icw1_wr   = wr & ~A0 & dataBus[4];
    assign ocw2_eoi  = wr & ~A0 & (dataBus[4:3] == 2'b00) & dataBus[5] & (init_q == READY);

    // A request is blocked by any in-service bit at its own or a higher priority.
    always_comb begin
        eligible = '0;
        blocked  = 1'b0;
        for (int j = 0; j < NUM_IRQ; j++) begin
            blocked     = blocked | isr_q[j];
            eligible[j] = irr[j] & ~imr_q[j] & ~blocked;
        end
        any_elig = |eligible;
        win_idx  = IDX_W'(NUM_IRQ - 1);
        for (int j = NUM_IRQ - 1; j >= 0; j--) begin
            if (eligible[j]) win_idx = IDX_W'(j);
        end
    end

    // EOI works on the pre-cycle ISR; the acknowledge set is applied last so it wins.
    always_comb begin
        isr_d = isr_q;
        found = 1'b0;
        if (ocw2_eoi) begin
            if (dataBus[6]) begin
                for (int j = 0; j < NUM_IRQ; j++) begin
                    if (dataBus[2:0] == 3'(j)) isr_d[j] = 1'b0;
                end
            end else begin
                for (int j = 0; j < NUM_IRQ; j++) begin
                    if (!found && isr_q[j]) begin
                        isr_d[j] = 1'b0;
                        found    = 1'b1;
                    end
                end
            end
        end
        if (ack_q == A_ACK2 && inta_rise && icw4_q[1] && !spur_q) isr_d[idx_q] = 1'b0;
        if (ack_q == A_IDLE && inta_fall && any_elig) isr_d[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= UNINIT;
            ack_q  <= A_IDLE;
            icw1_q <= '0;
            icw2_q <= '0;
            icw3_q <= '0;
            icw4_q <= '0;
            imr_q  <= '0;
            isr_q  <= '0;
            idx_q  <= '0;
            spur_q <= 1'b0;
            int_q  <= 1'b0;
            vec_q  <= '0;
            dir_q  <= 1'b0;
            inta_q <= 1'b1;
        end else begin
            inta_q <= INTA;
            if (icw1_wr) begin
                icw1_q <= dataBus;
                if (!dataBus[0]) icw4_q <= '0;
                init_q <= W_ICW2;
                imr_q  <= '0;
                isr_q  <= '0;
                ack_q  <= A_IDLE;
                int_q  <= 1'b0;
                dir_q  <= 1'b0;
            end else begin
                isr_q <= isr_d;
                if (wr && A0) begin
                    case (init_q)
                        W_ICW2: begin
                            icw2_q <= dataBus;
                            if (!icw1_q[1])    init_q <= W_ICW3;
                            else if (icw1_q[0]) init_q <= W_ICW4;
                            else               init_q <= READY;
                        end
                        W_ICW3: begin
                            icw3_q <= dataBus;
                            init_q <= icw1_q[0] ? W_ICW4 : READY;
                        end
                        W_ICW4: begin
                            icw4_q <= dataBus;
                            init_q <= READY;
                        end
                        READY:   imr_q <= dataBus[NUM_IRQ-1:0];
                        default: ;
                    endcase
                end

                case (ack_q)
                    A_IDLE: begin
                        int_q <= (init_q == READY) && any_elig;
                        if (inta_fall) begin
                            ack_q  <= A_ACK1;
                            int_q  <= 1'b0;
                            idx_q  <= win_idx;
                            spur_q <= ~any_elig;
                        end
                    end
                    A_ACK1: begin
                        if (inta_fall) begin
                            ack_q <= A_ACK2;
                            vec_q <= {icw2_q[7:IDX_W], idx_q};
                            dir_q <= 1'b1;
                        end
                    end
                    A_ACK2: begin
                        if (inta_rise) begin
                            ack_q <= A_IDLE;
                            dir_q <= 1'b0;
                        end
                    end
                    default: ack_q <= A_IDLE;
                endcase
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{icw1_q[7:2], icw3_q, icw4_q[7:2], icw4_q[0]};

    assign INT            = int_q;
    assign vector_address = vec_q;
    assign Direction      = dir_q;
    assign isr            = isr_q;
    assign imr            = imr_q;
    assign init_done      = (init_q == READY);

endmodule
